// File: rtl/dram_arbiter.sv
// dram_arbiter: two-master arbiter in front of a single-port DRAM with combinational read data.
//
// Every transaction takes three cycles: IDLE samples the requests and latches the winner's
// qualifiers, ACCESS drives the DRAM for one cycle, and RESP pulses the winner's ack for one cycle.
// Addresses at or above ADDR_LIMIT are flagged with err. They never write, and a read of one
// returns zero.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   m0_req/we/adr/wdata       CPU data-port request and qualifiers
//   m0_rdata/ack/err          CPU read data, completion pulse, address error (valid with ack)
//   m1_*                      same as m0_*, for the loader/debug port
//   dram_adr/wdin/we          DRAM address, write data, write strobe
//   dram_rd                   DRAM combinational read data
//   gnt                       one-hot owner during ACCESS/RESP (bit0 = m0, bit1 = m1)
module dram_arbiter #(
  parameter int unsigned   AW         = 32,
  parameter int unsigned   DW         = 32,
  parameter logic [AW-1:0] ADDR_LIMIT = AW'(32'h0000_1000),
  parameter bit            RR         = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] dram_adr,
  output logic [DW-1:0] dram_wdin,
  output logic          dram_we,
  input  logic [DW-1:0] dram_rd,
  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;    // last winner: 0 = m0, 1 = m1
  logic          win_q, win_d;      // current owner: 0 = m0, 1 = m1
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m0_err_q, m0_err_d;
  logic          m1_err_q, m1_err_d;

  logic          any_req;
  logic          pick;              // arbitration result: 0 = m0, 1 = m1
  logic          in_range;
  logic [DW-1:0] rd_val;

  // Unsigned compare over the full address width.
  assign in_range = (adr_q < ADDR_LIMIT);

  // Arbitration
  always_comb begin
    any_req = m0_req | m1_req;
    pick    = 1'b0;
    if (RR) begin
      // On a tie the master that did not win last goes first.
      if (m0_req && m1_req) begin
        pick = ~last_q;
      end else begin
        pick = m1_req;
      end
    end else begin
      pick = ~m0_req & m1_req;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
    rd_val     = in_range ? dram_rd : '0;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? m1_we    : m0_we;
          adr_d   = pick ? m1_adr   : m0_adr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Writes leave the winner's read data untouched.
        if (!we_q) begin
          if (win_q) begin
            m1_rdata_d = rd_val;
          end else begin
            m0_rdata_d = rd_val;
          end
        end
        if (win_q) begin
          m1_err_d = ~in_range;
        end else begin
          m0_err_d = ~in_range;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;           // m0 wins the first tie after reset
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
    end
  end

  // Outputs are decoded from state so that an asynchronous reset drops dram_we, ack and gnt
  // immediately instead of at the next edge.
  always_comb begin
    dram_adr  = adr_q;
    dram_wdin = wdata_q;
    dram_we   = (state_q == StAccess) & we_q & in_range;
    gnt       = (state_q == StIdle) ? 2'b00 : {win_q, ~win_q};
    m0_ack    = (state_q == StResp) & ~win_q;
    m1_ack    = (state_q == StResp) & win_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    m0_err    = m0_err_q;
    m1_err    = m1_err_q;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;

  localparam logic [31:0] LIMIT = 32'h0000_1000;

  logic        clk;
  logic        rst;

  // Round-robin instance
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_adr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_adr, m1_wdata, m1_rdata;
  logic [31:0] dram_adr, dram_wdin, dram_rd;
  logic        dram_we;
  logic [1:0]  gnt;

  // Fixed-priority instance
  logic        f_m0_req, f_m0_we, f_m0_ack, f_m0_err;
  logic [31:0] f_m0_adr, f_m0_wdata, f_m0_rdata;
  logic        f_m1_req, f_m1_we, f_m1_ack, f_m1_err;
  logic [31:0] f_m1_adr, f_m1_wdata, f_m1_rdata;
  logic [31:0] f_dram_adr, f_dram_wdin, f_dram_rd;
  logic        f_dram_we;
  logic [1:0]  f_gnt;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] model_rdata [2];
  int          n_vec;
  int          n_err;

  dram_arbiter #(.AW(32), .DW(32), .ADDR_LIMIT(LIMIT), .RR(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .dram_adr(dram_adr), .dram_wdin(dram_wdin), .dram_we(dram_we), .dram_rd(dram_rd),
    .gnt(gnt)
  );

  dram_arbiter #(.AW(32), .DW(32), .ADDR_LIMIT(LIMIT), .RR(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .m0_req(f_m0_req), .m0_we(f_m0_we), .m0_adr(f_m0_adr), .m0_wdata(f_m0_wdata),
    .m0_rdata(f_m0_rdata), .m0_ack(f_m0_ack), .m0_err(f_m0_err),
    .m1_req(f_m1_req), .m1_we(f_m1_we), .m1_adr(f_m1_adr), .m1_wdata(f_m1_wdata),
    .m1_rdata(f_m1_rdata), .m1_ack(f_m1_ack), .m1_err(f_m1_err),
    .dram_adr(f_dram_adr), .dram_wdin(f_dram_wdin), .dram_we(f_dram_we), .dram_rd(f_dram_rd),
    .gnt(f_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM model: word-indexed, aliases every 4 KiB.
  assign dram_rd   = mem[dram_adr[11:2]];
  assign f_dram_rd = mem[f_dram_adr[11:2]];
  always @(posedge clk) begin
    if (dram_we) mem[dram_adr[11:2]] <= dram_wdin;
  end

  task automatic push_exp(input int m, input logic we, input logic [31:0] adr,
                          input logic [31:0] wdata);
    exp_t e;
    logic inr;
    inr   = (adr < LIMIT);
    e.err = ~inr;
    if (we) begin
      e.rdata = model_rdata[m];
      if (inr) ref_mem[adr[11:2]] = wdata;
    end else begin
      e.rdata = inr ? ref_mem[adr[11:2]] : 32'h0;
    end
    model_rdata[m] = e.rdata;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] adr,
                       input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_adr = adr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_adr = adr; m1_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    model_rdata[0] = '0;
    model_rdata[1] = '0;
  endtask

  // One isolated transaction on master m; starts and ends with the DUT in IDLE.
  task automatic xfer(input string name, input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdata);
    exp_t        e;
    logic        got;
    logic        ack, oth_ack, err_now;
    logic [31:0] rd_now;
    int          lat, we_cycles, exp_we;
    exp_we = (we && (adr < LIMIT)) ? 1 : 0;
    push_exp(m, we, adr, wdata);
    drive(m, 1'b1, we, adr, wdata);
    got = 1'b0;
    lat = 0;
    we_cycles = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(posedge clk);
      #1;
      if (dram_we) begin
        we_cycles++;
        n_vec++;
        if (dram_adr !== adr || dram_wdin !== wdata) begin
          n_err++;
          $display("FAIL %s dram_adr/wdin: got %h/%h want %h/%h", name, dram_adr, dram_wdin,
                   adr, wdata);
        end
      end
      ack     = (m == 1) ? m1_ack : m0_ack;
      oth_ack = (m == 1) ? m0_ack : m1_ack;
      if (oth_ack) begin
        n_vec++;
        n_err++;
        $display("FAIL %s wrong master acked: got 1 want 0", name);
      end
      if (ack) begin
        got = 1'b1;
        lat = c;
        drive(m, 1'b0, we, adr, wdata);
        rd_now  = (m == 1) ? m1_rdata : m0_rdata;
        err_now = (m == 1) ? m1_err : m0_err;
        e = (m == 1) ? q1.pop_front() : q0.pop_front();
        n_vec++;
        if (rd_now !== e.rdata || err_now !== e.err) begin
          n_err++;
          $display("FAIL %s rdata/err: got %h/%b want %h/%b", name, rd_now, err_now,
                   e.rdata, e.err);
        end
        n_vec++;
        if (gnt !== ((m == 1) ? 2'b10 : 2'b01)) begin
          n_err++;
          $display("FAIL %s gnt at ack: got %b want %b", name, gnt, (m == 1) ? 2'b10 : 2'b01);
        end
      end
    end
    n_vec++;
    if (!got || lat != 2) begin
      n_err++;
      $display("FAIL %s ack latency: got %0d want 2 (acked=%b)", name, lat, got);
      if (!got) begin
        drive(m, 1'b0, we, adr, wdata);
        if (m == 1) void'(q1.pop_front());
        else        void'(q0.pop_front());
      end
    end
    n_vec++;
    if (we_cycles != exp_we) begin
      n_err++;
      $display("FAIL %s dram_we cycles: got %0d want %0d", name, we_cycles, exp_we);
    end
    // Back in IDLE: ack gone, err holds its last value.
    @(posedge clk);
    #1;
    ack     = (m == 1) ? m1_ack : m0_ack;
    err_now = (m == 1) ? m1_err : m0_err;
    n_vec++;
    if (ack !== 1'b0 || err_now !== ~(adr < LIMIT) || gnt !== 2'b00) begin
      n_err++;
      $display("FAIL %s idle hold ack/err/gnt: got %b/%b/%b want 0/%b/00", name, ack, err_now,
               gnt, ~(adr < LIMIT));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({dram_we, gnt, m0_ack, m1_ack, m0_err, m1_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset ctrl: got %b want 0000000",
               {dram_we, gnt, m0_ack, m1_ack, m0_err, m1_err});
    end
    n_vec++;
    if (dram_adr !== 32'h0 || dram_wdin !== 32'h0) begin
      n_err++;
      $display("FAIL reset dram bus: got %h/%h want 0/0", dram_adr, dram_wdin);
    end
    n_vec++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    xfer("m0_wr_10", 0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    xfer("m0_rd_10", 0, 1'b0, 32'h10, 32'h0);
    xfer("m0_wr_20", 0, 1'b1, 32'h20, 32'h1111_2222);
    xfer("m1_wr_14", 1, 1'b1, 32'h14, 32'h5555_AAAA);
    xfer("m1_rd_14", 1, 1'b0, 32'h14, 32'h0);
  endtask

  task automatic test_out_of_range();
    xfer("m1_wr_limit", 1, 1'b1, LIMIT, 32'h0BAD_0BAD);
    xfer("m1_rd_limit_m4", 1, 1'b0, LIMIT - 32'd4, 32'h0);
    xfer("m1_rd_high", 1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    xfer("m0_rd_alias0", 0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_round_robin();
    exp_t        e;
    int          exp_m, am, last_t, acks;
    logic [31:0] rd_now;
    logic        err_now;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 1'b0, 32'h10, 32'h0);
      push_exp(1, 1'b0, 32'h14, 32'h0);
    end
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
    exp_m  = 0;
    last_t = 0;
    acks   = 0;
    for (int c = 1; c <= 40 && acks < 6; c++) begin
      @(posedge clk);
      #1;
      if (m0_ack || m1_ack) begin
        am = m1_ack ? 1 : 0;
        n_vec++;
        if (am != exp_m || (m0_ack && m1_ack)) begin
          n_err++;
          $display("FAIL rr order #%0d: got m%0d want m%0d", acks, am, exp_m);
        end
        n_vec++;
        if (c - last_t != ((acks == 0) ? 2 : 3)) begin
          n_err++;
          $display("FAIL rr spacing #%0d: got %0d want %0d", acks, c - last_t,
                   (acks == 0) ? 2 : 3);
        end
        rd_now  = (am == 1) ? m1_rdata : m0_rdata;
        err_now = (am == 1) ? m1_err : m0_err;
        if ((am == 1 && q1.size() == 0) || (am == 0 && q0.size() == 0)) begin
          n_vec++;
          n_err++;
          $display("FAIL rr extra ack: got m%0d want none", am);
        end else begin
          e = (am == 1) ? q1.pop_front() : q0.pop_front();
          n_vec++;
          if (rd_now !== e.rdata || err_now !== e.err) begin
            n_err++;
            $display("FAIL rr data #%0d: got %h/%b want %h/%b", acks, rd_now, err_now,
                     e.rdata, e.err);
          end
        end
        last_t = c;
        exp_m  = 1 - exp_m;
        acks++;
        if (acks == 6) begin
          drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
          drive(1, 1'b0, 1'b0, 32'h14, 32'h0);
        end
      end
    end
    n_vec++;
    if (acks != 6 || q0.size() != 0 || q1.size() != 0) begin
      n_err++;
      $display("FAIL rr completion: got %0d acks want 6", acks);
      drive(0, 1'b0, 1'b0, 32'h10, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h14, 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fixed_priority();
    int   m0acks, drop_t, bad, m1_t;
    logic m1done;
    f_m0_req = 1'b1; f_m0_we = 1'b0; f_m0_adr = 32'h10;
    f_m1_req = 1'b1; f_m1_we = 1'b0; f_m1_adr = 32'h14;
    m0acks = 0;
    drop_t = 0;
    bad    = 0;
    m1_t   = 0;
    m1done = 1'b0;
    for (int c = 1; c <= 60 && !m1done; c++) begin
      @(posedge clk);
      #1;
      if (f_gnt[1] && f_m0_req) bad++;
      if (f_m0_ack) begin
        m0acks++;
        n_vec++;
        if (f_m0_rdata !== ref_mem[4] || f_m0_err !== 1'b0) begin
          n_err++;
          $display("FAIL fix m0 data: got %h/%b want %h/0", f_m0_rdata, f_m0_err, ref_mem[4]);
        end
        if (m0acks == 4) begin
          f_m0_req = 1'b0;
          drop_t   = c;
        end
      end
      if (f_m1_ack) begin
        m1done   = 1'b1;
        m1_t     = c;
        f_m1_req = 1'b0;
        n_vec++;
        if (f_m1_rdata !== ref_mem[5] || f_m1_err !== 1'b0) begin
          n_err++;
          $display("FAIL fix m1 data: got %h/%b want %h/0", f_m1_rdata, f_m1_err, ref_mem[5]);
        end
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL fix m1 granted under m0_req: got %0d cycles want 0", bad);
    end
    n_vec++;
    if (!m1done || m0acks != 4 || m1_t - drop_t != 3) begin
      n_err++;
      $display("FAIL fix m1 service: got m0acks=%0d delay=%0d want 4/3", m0acks, m1_t - drop_t);
    end
    f_m0_req = 1'b0;
    f_m1_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int stray;
    drive(0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    n_vec++;
    if (dram_we !== 1'b1) begin
      n_err++;
      $display("FAIL abort pre dram_we: got %b want 1", dram_we);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (dram_we !== 1'b0 || gnt !== 2'b00 || m0_ack !== 1'b0) begin
      n_err++;
      $display("FAIL abort async we/gnt/ack: got %b/%b/%b want 0/00/0", dram_we, gnt, m0_ack);
    end
    n_vec++;
    if (m0_rdata !== 32'h0 || m0_err !== 1'b0 || dram_adr !== 32'h0) begin
      n_err++;
      $display("FAIL abort async rdata/err/adr: got %h/%b/%h want 0/0/0", m0_rdata, m0_err,
               dram_adr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
    q0.delete();
    q1.delete();
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (m0_ack || m1_ack || dram_we) stray++;
    end
    n_vec++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL abort stray activity: got %0d cycles want 0", stray);
    end
    xfer("abort_rd_20", 0, 1'b0, 32'h20, 32'h0);
    xfer("after_wr_20", 0, 1'b1, 32'h20, 32'hCAFE_F00D);
    xfer("after_rd_20", 0, 1'b0, 32'h20, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    model_rdata[0] = '0;
    model_rdata[1] = '0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    f_m0_req = 1'b0; f_m0_we = 1'b0; f_m0_adr = '0; f_m0_wdata = '0;
    f_m1_req = 1'b0; f_m1_we = 1'b0; f_m1_adr = '0; f_m1_wdata = '0;

    test_reset();
    test_write_read();
    test_out_of_range();
    test_round_robin();
    test_fixed_priority();
    test_reset_abort();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter ADDR_LIMIT, default 32'h0000_1000, first illegal byte address.
REQ-004 SHALL have parameter RR, default 1, arbitration mode: 1 = round-robin, 0 = fixed m0 priority.
REQ-005 SHALL have ports, in this order:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  CPU data-port request.
- m0_we  in  1  CPU write enable.
- m0_adr  in  AW  CPU address.
- m0_wdata  in  DW  CPU write data.
- m0_rdata  out  DW  CPU read data.
- m0_ack  out  1  CPU completion pulse.
- m0_err  out  1  CPU address error, valid with m0_ack.
- m1_req, m1_we, m1_adr, m1_wdata, m1_rdata, m1_ack, m1_err: same as m0, for the loader/debug port.
- dram_adr  out  AW  DRAM address.
- dram_wdin  out  DW  DRAM write data.
- dram_we  out  1  DRAM write strobe.
- dram_rd  in  DW  DRAM combinational read data.
- gnt  out  2  one-hot current owner (bit0 = m0, bit1 = m1).

Function
REQ-006 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-007 IDLE SHALL sample the requests at the clock edge; if any mN_req is high, it SHALL:
- latch the winner's we/adr/wdata and winner id;
- go to ACCESS.
Otherwise it SHALL stay in IDLE.
REQ-008 RR=1 SHALL grant per a one-bit last-winner pointer:
- on a simultaneous request, the master that did not win last SHALL win;
- the pointer SHALL update on every grant.
REQ-009 RR=0 SHALL grant m0 whenever m0_req is high.
REQ-010 ACCESS SHALL last exactly one cycle and SHALL drive dram_adr and dram_wdin from the latched values.
REQ-011 In ACCESS, dram_we SHALL equal the latched we AND (latched adr < ADDR_LIMIT).
REQ-012 dram_we SHALL be 0 in IDLE and RESP.
REQ-013 At the edge ending ACCESS:
- winner's rdata <= dram_rd for an in-range read;
- winner's rdata <= 0 for an out-of-range read;
- winner's rdata SHALL be unchanged for a write;
- winner's err <= (adr >= ADDR_LIMIT);
- go to RESP.
REQ-014 RESP SHALL last exactly one cycle and SHALL assert only the winner's ack; RESP SHALL then always go to IDLE.
REQ-015 Latency SHALL be: request sampled at edge N, ack high during cycle N+2; one transaction per 3 cycles maximum.
REQ-016 A master SHALL hold req and its qualifiers stable until it samples ack; the arbiter SHALL ignore qualifier changes after the latch.
REQ-017 A losing master's request SHALL remain pending and SHALL be served in the next IDLE sample without a lost request.
REQ-018 gnt SHALL be one-hot of the latched winner in ACCESS and RESP, and 0 in IDLE.
REQ-019 mN_err SHALL be meaningful only while mN_ack=1, and SHALL hold its last value otherwise.
REQ-020 In IDLE, dram_adr and dram_wdin SHALL hold the last latched values (no X propagation).
REQ-021 Address comparison SHALL be unsigned over the full AW bits.

Reset
REQ-022 rst high SHALL asynchronously force:
- state = IDLE;
- the last-winner pointer = m1, so m0 wins the first tie;
- m0_ack = m1_ack = 0, m0_err = m1_err = 0;
- m0_rdata = m1_rdata = 0;
- latched adr/wdata/we = 0, so dram_adr = dram_wdin = 0 and dram_we = 0;
- gnt = 0.
REQ-023 rst asserted mid-ACCESS SHALL drop dram_we in the same cycle; no ack SHALL be issued for the aborted transaction.
REQ-024 After rst deasserts, the first request SHALL be sampled at the first rising clk edge with rst low.

Verification
REQ-025 m0 write adr=0x10 wdata=0xDEADBEEF -> dram_we=1 for one cycle with dram_adr=0x10; m0_ack one cycle later with m0_err=0.
REQ-026 m0 read adr=0x10 following REQ-025 -> m0_ack at sample+2 with m0_rdata=0xDEADBEEF and m0_err=0.
REQ-027 RR=1, m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, ... with each ack spaced 3 cycles apart.
REQ-028 RR=0, both request continuously -> m1 is never granted while m0_req stays high; m1 is served in the first IDLE after m0 drops.
REQ-029 m1 write adr=ADDR_LIMIT -> dram_we stays 0; m1_ack with m1_err=1; a subsequent read of ADDR_LIMIT-4 is unaffected.
REQ-030 rst pulsed during ACCESS of an m0 write -> dram_we falls immediately, no m0_ack, gnt=0; the next m0 request completes normally.
